ni_tx_arbiter: RTL

NI_TX_ARBITER -- requirements
Module: ni_tx_arbiter

---
 rtl/ni_tx_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ni_tx_arbiter.sv
// Round-robin transmit arbiter: picks one of NUM_REQ sources and streams its packet as flits.
// Optional header flit per packet enabled by defining NI_ARB_HDR_EN.
module ni_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [4*NUM_REQ-1:0]        len_in,
  input  logic [DATA_W*NUM_REQ-1:0]   src_data,
  output logic [NUM_REQ-1:0]          src_pop,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DATA_W-1:0]           flit_out,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic                        packet_end,
  output logic                        busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned LEN_W = 4;
  localparam int unsigned PAD_W = DATA_W - ID_W - LEN_W;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [ID_W-1:0]     win_q;
  logic [ID_W-1:0]     last_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     idx;
  logic                hs;

  // Round-robin search starting one past the previous winner
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = last_q + ID_W'(k);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    flit_valid = 1'b0;
    flit_out   = '0;
    packet_end = 1'b0;
    src_pop    = '0;
    busy       = 1'b0;
    hs         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
`ifdef NI_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = BODY;
`endif
        end
      end
      HDR: begin
        flit_valid = 1'b1;
        busy       = 1'b1;
        flit_out   = {win_q, len_q, PAD_W'(0)};
        hs         = flit_ready;
        if (hs) state_d = BODY;
      end
      BODY: begin
        flit_valid = 1'b1;
        busy       = 1'b1;
        flit_out   = src_data[DATA_W*win_q +: DATA_W];
        packet_end = (cnt_q == '0);
        hs         = flit_ready;
        src_pop    = hs ? grant_q : '0;
        if (hs && cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      win_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        win_q   <= pick_id;
        grant_q <= NUM_REQ'(1) << pick_id;
        len_q   <= len_in[LEN_W*pick_id +: LEN_W];
        cnt_q   <= len_in[LEN_W*pick_id +: LEN_W];
      end else if (state_q == BODY && hs) begin
        if (cnt_q == '0) begin
          grant_q <= '0;
          last_q  <= win_q;
        end else begin
          cnt_q <= cnt_q - LEN_W'(1);
        end
      end
    end
  end

endmodule
